dsss_despreader: RTL and testbench



---
 rtl/dsss_despreader.sv | 176 +++++++++++++++++
 tb/tb_dsss_despreader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dsss_despreader.sv
// dsss_despreader: hard-decision DSSS correlator with symbol acquisition and lock tracking.
// Each window of CHIPS_PER_BIT received chips is correlated against PN_CODE.
// The block acquires symbol alignment in SEARCH, then recovers one bit per code period in LOCK.
// Build option: define DESPREAD_LOCK_LOSS_EN to compile in the miss counter and the
// loss-of-lock path. Without it, LOCK is left only through rst.
module dsss_despreader #(
  parameter int unsigned                CHIPS_PER_BIT = 8,
  parameter logic [CHIPS_PER_BIT-1:0]   PN_CODE       = 8'hB4,
  parameter int unsigned                THRESH        = 6,
  parameter int unsigned                MISS_MAX      = 3
) (
  input  logic                                   clk_100,
  input  logic                                   rst,
  input  logic                                   chip_en,
  input  logic                                   chip_in,
  output logic                                   bit_out,
  output logic                                   bit_valid,
  output logic signed [$clog2(CHIPS_PER_BIT)+1:0] corr_out,
  output logic                                   locked
);

  localparam int unsigned N    = CHIPS_PER_BIT;
  localparam int unsigned CW   = $clog2(N) + 2;
  localparam int unsigned AW   = $clog2(N + 1);
  localparam int unsigned CNTW = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int unsigned MW   = ($clog2(MISS_MAX + 1) > 0) ? $clog2(MISS_MAX + 1) : 1;

  // A zero miss limit would make every weak symbol unreachable as a lock-loss trigger.
  if (MISS_MAX < 1) begin : g_bad_miss_max
    $error("dsss_despreader: MISS_MAX must be at least 1");
  end

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCK   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [N-2:0]            sr_q, sr_d;
  logic [CNTW-1:0]         fill_q, fill_d;
  logic [CNTW-1:0]         chip_cnt_q, chip_cnt_d;
  logic                    bit_out_q, bit_out_d;
  logic                    bit_valid_q, bit_valid_d;
  logic signed [CW-1:0]    corr_out_q, corr_out_d;
  logic                    locked_q, locked_d;
`ifdef DESPREAD_LOCK_LOSS_EN
  logic [MW-1:0]           miss_cnt_q, miss_cnt_d;
`endif

  logic [N-1:0]            win_c;
  logic [N-1:0]            match_c;
  logic [AW-1:0]           agree_c;
  logic signed [CW-1:0]    corr_c;
  logic [CW-1:0]           mag_c;
  logic                    strong_c;
  logic                    dec_c;

  // Correlate the current window (past chips plus the live chip) against the code.
  always_comb begin
    win_c   = {sr_q, chip_in};
    match_c = ~(win_c ^ PN_CODE);
    agree_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      agree_c = agree_c + AW'(match_c[i]);
    end
    corr_c   = $signed(CW'({agree_c, 1'b0})) - $signed(CW'(N));
    mag_c    = corr_c[CW-1] ? CW'(-corr_c) : CW'(corr_c);
    strong_c = (mag_c >= CW'(THRESH));
    dec_c    = corr_c[CW-1];
  end

  // Next-state, counters and output register inputs.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    chip_cnt_d  = chip_cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    corr_out_d  = corr_out_q;
`ifdef DESPREAD_LOCK_LOSS_EN
    miss_cnt_d  = miss_cnt_q;
`endif

    if (chip_en) begin
      sr_d = win_c[N-2:0];
      if (fill_q != CNTW'(N - 1)) begin
        fill_d = fill_q + CNTW'(1);
      end

      case (state_q)
        S_SEARCH: begin
          // Slide one chip at a time until a full window correlates strongly.
          if ((fill_q == CNTW'(N - 1)) && strong_c) begin
            bit_valid_d = 1'b1;
            bit_out_d   = dec_c;
            corr_out_d  = corr_c;
            state_d     = S_LOCK;
            chip_cnt_d  = '0;
`ifdef DESPREAD_LOCK_LOSS_EN
            miss_cnt_d  = '0;
`endif
          end
        end

        S_LOCK: begin
          if (chip_cnt_q == CNTW'(N - 1)) begin
            chip_cnt_d = '0;
`ifdef DESPREAD_LOCK_LOSS_EN
            if (strong_c) begin
              miss_cnt_d  = '0;
              bit_valid_d = 1'b1;
              bit_out_d   = dec_c;
              corr_out_d  = corr_c;
            end else if ((miss_cnt_q + MW'(1)) == MW'(MISS_MAX)) begin
              // Too many weak symbols in a row: drop this bit and re-acquire.
              miss_cnt_d = '0;
              state_d    = S_SEARCH;
            end else begin
              miss_cnt_d  = miss_cnt_q + MW'(1);
              bit_valid_d = 1'b1;
              bit_out_d   = dec_c;
              corr_out_d  = corr_c;
            end
`else
            bit_valid_d = 1'b1;
            bit_out_d   = dec_c;
            corr_out_d  = corr_c;
`endif
          end else begin
            chip_cnt_d = chip_cnt_q + CNTW'(1);
          end
        end

        default: state_d = S_SEARCH;
      endcase
    end

    locked_d = (state_d == S_LOCK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q     <= S_SEARCH;
      sr_q        <= '0;
      fill_q      <= '0;
      chip_cnt_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      corr_out_q  <= '0;
      locked_q    <= 1'b0;
`ifdef DESPREAD_LOCK_LOSS_EN
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      chip_cnt_q  <= chip_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      corr_out_q  <= corr_out_d;
      locked_q    <= locked_d;
`ifdef DESPREAD_LOCK_LOSS_EN
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign corr_out  = corr_out_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_dsss_despreader.sv
// tb_dsss_despreader: directed self-checking bench for dsss_despreader (N=8, code B4).
module tb_dsss_despreader;

  localparam logic [7:0] PN = 8'hB4;

  logic              clk_100 = 1'b0;
  logic              rst     = 1'b1;
  logic              chip_en = 1'b0;
  logic              chip_in = 1'b0;
  logic              bit_out;
  logic              bit_valid;
  logic signed [4:0] corr_out;
  logic              locked;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   valid_cnt = 0;
  logic last_bit;
  logic last_locked;
  int   last_corr;

  always #5 clk_100 = ~clk_100;

  dsss_despreader dut (
    .clk_100   (clk_100),
    .rst       (rst),
    .chip_en   (chip_en),
    .chip_in   (chip_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .corr_out  (corr_out),
    .locked    (locked)
  );

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one chip, sample its T+1 result, then idle for gap cycles.
  task automatic send_chip(input logic c, input int gap);
    chip_en = 1'b1;
    chip_in = c;
    @(negedge clk_100);
    last_bit    = bit_out;
    last_corr   = int'(corr_out);
    last_locked = locked;
    if (bit_valid) valid_cnt++;
    chip_en = 1'b0;
    chip_in = 1'b0;
    repeat (gap) begin
      @(negedge clk_100);
      if (bit_valid) valid_cnt++;
    end
  endtask

  // Send 8 chips, first chip = bit 7, and check the resulting pulses and outputs.
  task automatic send_sym(input string tag, input logic [7:0] chips, input int gap,
                          input int exp_pulses, input int exp_bit, input int exp_corr,
                          input int exp_locked);
    int vc0 = valid_cnt;
    for (int i = 7; i >= 0; i--) send_chip(chips[i], gap);
    check({tag, ".pulses"}, valid_cnt - vc0, exp_pulses);
    if (exp_pulses > 0) begin
      check({tag, ".bit"}, int'(last_bit), exp_bit);
      check({tag, ".corr"}, last_corr, exp_corr);
    end
    check({tag, ".locked"}, int'(last_locked), exp_locked);
  endtask

  // Three zero pad chips: no partial window reaches |corr| >= 6 for either data value.
  task automatic send_pads(input string tag, input int gap);
    int vc0 = valid_cnt;
    for (int i = 0; i < 3; i++) send_chip(1'b0, gap);
    check({tag, ".pad_pulses"}, valid_cnt - vc0, 0);
    check({tag, ".pad_locked"}, int'(locked), 0);
  endtask

  // Hold rst 4 cycles while strobing ones; nothing may come out.
  task automatic do_reset(input string tag);
    int vc0 = valid_cnt;
    rst     = 1'b1;
    chip_en = 1'b1;
    chip_in = 1'b1;
    repeat (4) begin
      @(negedge clk_100);
      if (bit_valid) valid_cnt++;
    end
    rst     = 1'b0;
    chip_en = 1'b0;
    chip_in = 1'b0;
    check({tag, ".rst_pulses"}, valid_cnt - vc0, 0);
    check({tag, ".rst_locked"}, int'(locked), 0);
    check({tag, ".rst_corr"}, int'(corr_out), 0);
    check({tag, ".rst_bit"}, int'(bit_out), 0);
  endtask

  // Full acquisition / tracking / chip-error / weak-symbol sequence at a given strobe gap.
  task automatic run_seq(input string tag, input int gap);
    do_reset(tag);
    send_pads(tag, gap);
    send_sym({tag, ".acq"},  PN,            gap, 1, 0,  8, 1);
    send_sym({tag, ".s1"},   ~PN,           gap, 1, 1, -8, 1);
    send_sym({tag, ".s2"},   ~PN,           gap, 1, 1, -8, 1);
    send_sym({tag, ".s3"},   PN,            gap, 1, 0,  8, 1);
    send_sym({tag, ".f1a"},  PN ^ 8'h10,    gap, 1, 0,  6, 1);
    send_sym({tag, ".f1b"},  ~PN ^ 8'h01,   gap, 1, 1, -6, 1);
    send_sym({tag, ".f2"},   ~PN ^ 8'h81,   gap, 1, 1, -4, 1);
    send_sym({tag, ".good"}, PN,            gap, 1, 0,  8, 1);
    send_sym({tag, ".w1"},   8'hFF,         gap, 1, 0,  0, 1);
    send_sym({tag, ".w2"},   8'hFF,         gap, 1, 0,  0, 1);
`ifdef DESPREAD_LOCK_LOSS_EN
    send_sym({tag, ".w3"},   8'hFF,         gap, 0, 0,  0, 0);
`else
    send_sym({tag, ".w3"},   8'hFF,         gap, 1, 0,  0, 1);
`endif
  endtask

  initial begin
    run_seq("fast", 0);
    run_seq("slow", 99);

    // Reset coincident with the 5th chip of a symbol while locked.
    do_reset("mid");
    send_pads("mid", 0);
    send_sym("mid.acq", ~PN, 0, 1, 1, -8, 1);
    for (int i = 7; i >= 4; i--) send_chip(PN[i], 0);
    rst     = 1'b1;
    chip_en = 1'b1;
    chip_in = 1'b1;
    @(negedge clk_100);
    check("mid.rst_locked", int'(locked), 0);
    check("mid.rst_valid", int'(bit_valid), 0);
    check("mid.rst_corr", int'(corr_out), 0);
    check("mid.rst_bit", int'(bit_out), 0);
    rst     = 1'b0;
    chip_en = 1'b0;
    chip_in = 1'b0;
    @(negedge clk_100);
    send_pads("mid.re", 0);
    send_sym("mid.reacq", PN, 0, 1, 0, 8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time bound in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
